// File: rtl/axil_csr_bank.sv
// AXI4-Lite CSR bank: reg 0 is COMMAND/STATUS with start pulse, sticky done and irq;
// regs 1..NUM_REGS-1 are plain read/write registers exported flat on regs_o.
module axil_csr_bank #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ADDR_W-1:0]                s_axi_awaddr,
    input  logic                             s_axi_awvalid,
    output logic                             s_axi_awready,
    input  logic [DATA_W-1:0]                s_axi_wdata,
    input  logic [DATA_W/8-1:0]              s_axi_wstrb,
    input  logic                             s_axi_wvalid,
    output logic                             s_axi_wready,
    output logic [1:0]                       s_axi_bresp,
    output logic                             s_axi_bvalid,
    input  logic                             s_axi_bready,
    input  logic [ADDR_W-1:0]                s_axi_araddr,
    input  logic                             s_axi_arvalid,
    output logic                             s_axi_arready,
    output logic [DATA_W-1:0]                s_axi_rdata,
    output logic [1:0]                       s_axi_rresp,
    output logic                             s_axi_rvalid,
    input  logic                             s_axi_rready,
    output logic [DATA_W-1:0]                cmd_o,
    output logic                             start_o,
    input  logic                             done_i,
    output logic                             irq_o,
    output logic [(NUM_REGS-1)*DATA_W-1:0]   regs_o
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - OFF_W;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    logic                aw_full_q, w_full_q;
    logic [IDX_W-1:0]    aw_idx_q;
    logic [DATA_W-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic                bvalid_q, rvalid_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic                done_flag_q, start_q;

    logic                aw_hs, w_hs, ar_hs, commit;
    logic [NUM_REGS-1:0] wr_sel, wr_en;
    logic                wr_hit, rd_hit, cmd_rise, done_clr, done_flag_d;
    logic [DATA_W-1:0]   cmd_new, status, rd_data;
    logic [IDX_W-1:0]    ar_idx;
    logic                unused_addr;

    assign unused_addr = ^{s_axi_awaddr[OFF_W-1:0], s_axi_araddr[OFF_W-1:0]};

    assign s_axi_awready = ~aw_full_q & ~bvalid_q;
    assign s_axi_wready  = ~w_full_q & ~bvalid_q;
    assign s_axi_arready = ~rvalid_q;
    assign aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_hs   = s_axi_wvalid & s_axi_wready;
    assign ar_hs  = s_axi_arvalid & s_axi_arready;
    assign commit = aw_full_q & w_full_q;
    assign ar_idx = s_axi_araddr[ADDR_W-1:OFF_W];
    assign status = {regs_q[0][DATA_W-1:2], regs_q[0][0] & ~done_flag_q, done_flag_q};

    always_comb begin
        wr_sel  = '0;
        rd_hit  = 1'b0;
        rd_data = '0;
        for (int unsigned k = 0; k < NUM_REGS; k++) begin
            if (aw_idx_q == IDX_W'(k)) wr_sel[k] = 1'b1;
            if (ar_idx == IDX_W'(k)) begin
                rd_hit  = 1'b1;
                rd_data = (k == 0) ? status : regs_q[k];
            end
        end
        wr_hit = |wr_sel;
        wr_en  = wr_sel & {NUM_REGS{commit}};
    end

    always_comb begin
        cmd_new = regs_q[0];
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) cmd_new[b*8 +: 8] = w_data_q[b*8 +: 8];
        end
        cmd_rise    = wr_en[0] & ~regs_q[0][0] & cmd_new[0];
        done_clr    = wr_en[0] & (cmd_rise | ~cmd_new[0]);
        // A completion in the same cycle as a clearing write wins.
        done_flag_d = done_i | (done_flag_q & ~done_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (wr_en[k]) begin
                    for (int unsigned b = 0; b < STRB_W; b++) begin
                        if (w_strb_q[b]) regs_q[k][b*8 +: 8] <= w_data_q[b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full_q   <= 1'b0;
            aw_idx_q    <= '0;
            w_full_q    <= 1'b0;
            w_data_q    <= '0;
            w_strb_q    <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
            rvalid_q    <= 1'b0;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            done_flag_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= s_axi_awaddr[ADDR_W-1:OFF_W];
            end
            if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= s_axi_wdata;
                w_strb_q <= s_axi_wstrb;
            end
            if (commit) begin
                aw_full_q <= 1'b0;
                w_full_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_q && s_axi_rready) begin
                rvalid_q <= 1'b0;
            end
            done_flag_q <= done_flag_d;
            start_q     <= cmd_rise;
        end
    end

    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;
    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_rdata  = rdata_q;
    assign cmd_o        = regs_q[0];
    assign start_o      = start_q;
    assign irq_o        = done_flag_q & regs_q[0][1];

    for (genvar k = 1; k < NUM_REGS; k++) begin : g_regs_o
        assign regs_o[k*DATA_W-1 -: DATA_W] = regs_q[k];
    end

endmodule

// File: tb/tb_axil_csr_bank.sv
// Randomised self-checking bench for axil_csr_bank against a register-array reference model.
module tb_axil_csr_bank;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 8;
    localparam int RW       = (NUM_REGS - 1) * DATA_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] s_axi_awaddr = '0;
    logic              s_axi_awvalid = 1'b0;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata = '0;
    logic [3:0]        s_axi_wstrb = '0;
    logic              s_axi_wvalid = 1'b0;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready = 1'b0;
    logic [ADDR_W-1:0] s_axi_araddr = '0;
    logic              s_axi_arvalid = 1'b0;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready = 1'b0;
    logic [31:0]       cmd_o;
    logic              start_o;
    logic              done_i = 1'b0;
    logic              irq_o;
    logic [RW-1:0]     regs_o;

    axil_csr_bank #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .cmd_o(cmd_o),
        .start_o(start_o), .done_i(done_i), .irq_o(irq_o), .regs_o(regs_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails = 0;
    int start_cnt = 0;
    always @(negedge clk) if (start_o === 1'b1) start_cnt++;

    // Reference model: register contents plus sticky done flag.
    logic [31:0] m_reg [NUM_REGS];
    bit          m_done;

    function automatic void model_reset();
        for (int k = 0; k < NUM_REGS; k++) m_reg[k] = '0;
        m_done = 1'b0;
    endfunction

    // Returns 1 when the write should produce a start pulse.
    function automatic bit model_write(int idx, logic [31:0] d, logic [3:0] s);
        logic [31:0] old, nv;
        bit rise;
        if (idx >= NUM_REGS) return 1'b0;
        old = m_reg[idx];
        nv  = old;
        for (int b = 0; b < 4; b++) if (s[b]) nv[b*8 +: 8] = d[b*8 +: 8];
        m_reg[idx] = nv;
        if (idx != 0) return 1'b0;
        rise = !old[0] && nv[0];
        if (rise || !nv[0]) m_done = 1'b0;
        return rise;
    endfunction

    function automatic logic [31:0] model_read(int idx);
        if (idx >= NUM_REGS) return 32'h0;
        if (idx == 0) return {m_reg[0][31:2], m_reg[0][0] & ~m_done, m_done};
        return m_reg[idx];
    endfunction

    function automatic logic [RW-1:0] model_regs();
        logic [RW-1:0] v;
        for (int k = 1; k < NUM_REGS; k++) v[(k-1)*32 +: 32] = m_reg[k];
        return v;
    endfunction

    // lead > 0: W offered lead cycles before AW; lead < 0: AW first.
    task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead, input int bhold,
                             output logic [1:0] resp);
        int t;
        bit aw_done, w_done, aw_hs, w_hs;
        t = 0; aw_done = 0; w_done = 0;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        while (!(aw_done && w_done) && t < 50) begin
            if (!aw_done && t >= ((lead > 0) ? lead : 0)) s_axi_awvalid = 1'b1;
            if (!w_done && t >= ((lead < 0) ? -lead : 0)) s_axi_wvalid = 1'b1;
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(negedge clk); t++;
            if (aw_hs) begin s_axi_awvalid = 1'b0; aw_done = 1; end
            if (w_hs) begin s_axi_wvalid = 1'b0; w_done = 1; end
        end
        t = 0;
        while (s_axi_bvalid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (!(aw_done && w_done) || s_axi_bvalid !== 1'b1) begin
            fails++;
            $display("FAIL write_handshake addr=%h: aw=%0d w=%0d bvalid=%b, required all 1",
                     addr, aw_done, w_done, s_axi_bvalid);
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        resp = s_axi_bresp;
        repeat (bhold) @(negedge clk);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [ADDR_W-1:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int t;
        bit hs;
        t = 0; hs = 0;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        while (!hs && t < 50) begin
            hs = s_axi_arready === 1'b1;
            @(negedge clk); t++;
        end
        s_axi_arvalid = 1'b0;
        t = 0;
        while (s_axi_rvalid !== 1'b1 && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (!hs || s_axi_rvalid !== 1'b1) begin
            fails++;
            $display("FAIL read_handshake addr=%h: ar=%0d rvalid=%b, required 1", addr, hs,
                     s_axi_rvalid);
        end
        data = s_axi_rdata; resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        @(negedge clk);
        done_i = 1'b0;
        m_done = 1'b1;
    endtask

    task automatic read_check(input string name, input int idx);
        logic [31:0] d;
        logic [1:0]  r;
        logic [1:0]  er;
        axi_read(ADDR_W'(idx * 4), d, r);
        er = (idx < NUM_REGS) ? 2'b00 : 2'b10;
        checks++;
        if (d !== model_read(idx) || r !== er) begin
            fails++;
            $display("FAIL %s idx=%0d: got data=%h resp=%b, required data=%h resp=%b", name, idx,
                     d, r, model_read(idx), er);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, start_o, irq_o} !== 8'h0 ||
            s_axi_rdata !== 32'h0 || cmd_o !== 32'h0 || regs_o !== '0) begin
            fails++;
            $display("FAIL reset_outputs: bv=%b rv=%b br=%b rr=%b st=%b irq=%b rd=%h cmd=%h",
                     s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, start_o, irq_o,
                     s_axi_rdata, cmd_o);
        end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin
            fails++;
            $display("FAIL reset_ready: got %b, required 111",
                     {s_axi_awready, s_axi_wready, s_axi_arready});
        end
    endtask

    task automatic test_basic();
        logic [1:0] r1, r2;
        axi_write(12'h004, 32'h100, 4'hf, 0, 0, r1); void'(model_write(1, 32'h100, 4'hf));
        axi_write(12'h008, 32'h080, 4'hf, 0, 0, r2); void'(model_write(2, 32'h080, 4'hf));
        checks++;
        if (r1 !== 2'b00 || r2 !== 2'b00) begin
            fails++; $display("FAIL basic_bresp: got %b %b, required 00 00", r1, r2);
        end
        checks++;
        if (regs_o[31:0] !== 32'h100 || regs_o[63:32] !== 32'h80) begin
            fails++;
            $display("FAIL basic_regs_o: got %h %h, required 100 80", regs_o[31:0], regs_o[63:32]);
        end
        read_check("basic_read1", 1);
        read_check("basic_read2", 2);
    endtask

    task automatic test_command();
        logic [1:0] r;
        int c0;
        bit exp_start;
        c0 = start_cnt;
        axi_write(12'h000, 32'h1, 4'hf, 0, 0, r); exp_start = model_write(0, 32'h1, 4'hf);
        checks++;
        if (start_cnt - c0 !== int'(exp_start) || cmd_o !== m_reg[0]) begin
            fails++;
            $display("FAIL cmd_start: pulses=%0d cmd=%h, required pulses=%0d cmd=%h",
                     start_cnt - c0, cmd_o, exp_start, m_reg[0]);
        end
        read_check("cmd_status_busy", 0);
        pulse_done();
        read_check("cmd_status_done", 0);
        axi_write(12'h000, 32'h0, 4'hf, 0, 0, r); void'(model_write(0, 32'h0, 4'hf));
        read_check("cmd_status_clear", 0);
    endtask

    task automatic test_w_first();
        logic [31:0] d;
        bit ok;
        d = $urandom;
        s_axi_wdata = d; s_axi_wstrb = 4'hf; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        ok = 1;
        for (int i = 0; i < 2; i++) begin
            if (s_axi_wready !== 1'b0 || s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) ok = 0;
            @(negedge clk);
        end
        checks++;
        if (!ok || s_axi_wready !== 1'b0) begin
            fails++; $display("FAIL wfirst_wready: got wready=%b, required 0", s_axi_wready);
        end
        s_axi_awaddr = 12'h010; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b0 || regs_o[127:96] !== m_reg[4]) begin
            fails++;
            $display("FAIL wfirst_early: bvalid=%b reg4=%h, required 0 %h", s_axi_bvalid,
                     regs_o[127:96], m_reg[4]);
        end
        void'(model_write(4, d, 4'hf));
        @(negedge clk);
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00 || regs_o[127:96] !== m_reg[4]) begin
            fails++;
            $display("FAIL wfirst_commit: bvalid=%b bresp=%b reg4=%h, required 1 00 %h",
                     s_axi_bvalid, s_axi_bresp, regs_o[127:96], m_reg[4]);
        end
        ok = 1;
        for (int i = 0; i < 4; i++) begin
            if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0 || s_axi_wready !== 1'b0) ok = 0;
            @(negedge clk);
        end
        checks++;
        if (!ok) begin
            fails++; $display("FAIL wfirst_bhold: bvalid=%b, required held 1", s_axi_bvalid);
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
            fails++;
            $display("FAIL wfirst_bdone: bvalid=%b awready=%b, required 0 1", s_axi_bvalid,
                     s_axi_awready);
        end
    endtask

    task automatic test_strobe();
        logic [1:0] r;
        axi_write(12'h00c, 32'hAABBCCDD, 4'hf, 0, 0, r); void'(model_write(3, 32'hAABBCCDD, 4'hf));
        axi_write(12'h00c, 32'h11223344, 4'h5, 0, 0, r); void'(model_write(3, 32'h11223344, 4'h5));
        read_check("strobe_read", 3);
        checks++;
        if (regs_o[95:64] !== 32'hAA22CC44) begin
            fails++; $display("FAIL strobe_regs_o: got %h, required aa22cc44", regs_o[95:64]);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] r;
        axi_write(ADDR_W'(NUM_REGS * 4), $urandom, 4'hf, 0, 0, r);
        checks++;
        if (r !== 2'b10 || regs_o !== model_regs() || cmd_o !== m_reg[0]) begin
            fails++;
            $display("FAIL oor_write: bresp=%b regs_o=%h, required 10 %h", r, regs_o, model_regs());
        end
        read_check("oor_read", NUM_REGS);
        read_check("oor_read_top", 1023);
    endtask

    task automatic test_irq_reset();
        logic [1:0] r;
        bit ok;
        axi_write(12'h000, 32'h3, 4'hf, 0, 0, r); void'(model_write(0, 32'h3, 4'hf));
        pulse_done();
        checks++;
        if (irq_o !== (m_done & m_reg[0][1])) begin
            fails++; $display("FAIL irq_set: got %b, required %b", irq_o, m_done & m_reg[0][1]);
        end
        s_axi_awaddr = 12'h004; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hf;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({s_axi_bvalid, s_axi_rvalid, s_axi_bresp, s_axi_rresp, start_o, irq_o} !== 8'h0 ||
            s_axi_rdata !== 32'h0 || cmd_o !== 32'h0 || regs_o !== '0) begin
            fails++;
            $display("FAIL rst_mid_write: bv=%b rv=%b irq=%b rd=%h cmd=%h regs_o=%h, required 0",
                     s_axi_bvalid, s_axi_rvalid, irq_o, s_axi_rdata, cmd_o, regs_o);
        end
        @(negedge clk);
        rst = 1'b0;
        ok = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) ok = 0;
        end
        checks++;
        if (!ok) begin
            fails++; $display("FAIL rst_no_response: bvalid=%b, required 0", s_axi_bvalid);
        end
        read_check("rst_reg1", 1);
    endtask

    task automatic test_random();
        logic [1:0]  r, er;
        logic [31:0] d;
        logic [3:0]  s;
        int idx, c0;
        bit exp_start;
        for (int i = 0; i < 60; i++) begin
            idx = $urandom_range(0, NUM_REGS + 1);
            if ($urandom_range(0, 7) == 0) pulse_done();
            if ($urandom_range(0, 1) == 0) begin
                d = $urandom; s = 4'($urandom);
                c0 = start_cnt;
                axi_write(ADDR_W'(idx * 4 + $urandom_range(0, 3)), d, s,
                          $urandom_range(0, 4) - 2, $urandom_range(0, 2), r);
                exp_start = model_write(idx, d, s);
                er = (idx < NUM_REGS) ? 2'b00 : 2'b10;
                checks++;
                if (r !== er || regs_o !== model_regs() || cmd_o !== m_reg[0] ||
                    start_cnt - c0 !== int'(exp_start)) begin
                    fails++;
                    $display("FAIL rand_write idx=%0d: bresp=%b cmd=%h pulses=%0d, required %b %h %0d",
                             idx, r, cmd_o, start_cnt - c0, er, m_reg[0], exp_start);
                end
            end else begin
                read_check("rand_read", idx);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_command();
        test_w_first();
        test_strobe();
        test_out_of_range();
        test_irq_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axil_csr_bank.md
# axil_csr_bank

Parametrised AXI4-Lite control/status register bank between the processor CSR port and an accelerator core such as the ECDSA datapath. Register 0 is a command/status register with start-pulse generation, a sticky done flag and an optional interrupt. Registers 1..NUM_REGS-1 are general read/write registers, for example memory RX/TX addresses, exported to the core as a flat bus. Address and data channels are accepted in any order, and out-of-range accesses return SLVERR.

## Interface
Parameters:
- ADDR_W, 12, AXI byte-address width
- DATA_W, 32, register and data width; must be 32 or 64
- NUM_REGS, 8, number of registers including reg 0; range 2..256

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-high reset
- s_axi_awaddr  in  ADDR_W  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  DATA_W  write data
- s_axi_wstrb  in  DATA_W/8  byte strobes
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response: 00 OKAY, 10 SLVERR
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  ADDR_W  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  DATA_W  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- cmd_o  out  DATA_W  current COMMAND register value
- start_o  out  1  one-cycle pulse when COMMAND bit0 goes 0→1
- done_i  in  1  core completion pulse or level
- irq_o  out  1  level interrupt = done_flag & COMMAND bit1
- regs_o  out  (NUM_REGS-1)*DATA_W  regs 1..N-1, with reg k at bits [k*DATA_W-1 -: DATA_W]

## Operation
- Register index = addr >> log2(DATA_W/8). Low address bits are ignored. Index ≥ NUM_REGS is out of range.
- Write path has two independent capture slots, AW and W.
  - awready=1 while the AW slot is empty and bvalid=0. wready behaves the same for the W slot.
  - Once both slots are full, the write commits on the next clock edge. Both slots clear at the same edge and bvalid rises.
  - Commit applies only bytes whose wstrb bit is set.
  - Out-of-range write: no register changes; bresp=10.
- bvalid holds until bready, and the B handshake completes on that edge. No new AW/W is accepted while bvalid=1.
- Read path:
  - arready=1 while rvalid=0.
  - On the AR handshake, rdata/rresp are registered and rvalid rises.
  - rvalid, rdata and rresp hold until rready.
  - Out-of-range read: rdata=0, rresp=10.
- Reg 0 read returns STATUS = {cmd[DATA_W-1:2], busy, done_flag}, where busy = cmd[0] & ~done_flag.
- Reg 0 write:
  - Updates cmd.
  - If cmd[0] was 0 and the new bit0 is 1, start_o=1 for exactly the following cycle and done_flag clears.
  - Writing bit0=0 clears done_flag.
- done_flag sets on any cycle with done_i=1. If done_i=1 in the same cycle as a clearing write, set wins.
- Reads and writes are independent and may proceed in the same cycle. A read of a register committed on the same edge returns the old value.
- Reset values (while rst=1):
  - all registers, cmd_o, regs_o and done_flag = 0
  - start_o=0, irq_o=0
  - bvalid=0, rvalid=0, bresp=00, rresp=00, rdata=0
  - awready=1, wready=1, arready=1 once rst deasserts
- rst mid-transaction discards captured slots and pending responses without producing a response.

## Timing
- Write: AW and W both handshake at edge N → register updated and bvalid=1 at edge N+1 (latency 1).
- AW at edge N, W at edge M>N → commit and bvalid at edge M+1. The W-first case is symmetric.
- Read: AR handshake at edge N → rvalid=1 with data at edge N+1. Back-to-back reads need rready=1 for one-per-two-cycle throughput.
- start_o is high for the single cycle following the commit edge.
- irq_o follows done_flag with zero extra cycles (combinational from registered bits).

## Test plan
- Write reg1=0x100 and reg2=0x80 (AW and W simultaneous) → bresp=00; regs_o shows 0x100 and 0x80; readback matches.
- Write COMMAND=0x1 → one start_o pulse; STATUS reads 0x2 (busy). Pulse done_i → STATUS reads 0x1. Write COMMAND=0x0 → STATUS reads 0x0.
- W presented 3 cycles before AW → wready drops after the W capture; commit occurs 1 cycle after AW; bvalid held 4 cycles with bready=0.
- Write 0xAABBCCDD to reg3, then 0x11223344 with wstrb=0101 → reg3 reads 0xAA22CC44.
- Write and read at index NUM_REGS → bresp=10; rresp=10 with rdata=0; no register changes.
- Set COMMAND=0x3, pulse done_i → irq_o=1. Assert rst mid-write → all outputs return to reset values; no bvalid.
